sd_resp_rx: RTL and testbench

Receiver for 48-bit SD command-line responses (R1/R1b/R3/R6/R7 format). It is the host-side counterpart of the command CRC7 generator. Once armed, it hunts for the start bit on the CMD line, deserializes the frame, and recomputes CRC7 over the first 40 bits. It compares the result against the received CRC and reports index, argument, CRC and framing errors, or a response timeout, to the command FSM.

---
 rtl/sd_pkg.sv | 10 +
 rtl/sd_resp_rx_if.sv | 10 +
 rtl/sd_crc7_serial.sv | 15 +
 rtl/sd_resp_rx.sv | 64 ++++++
 tb/tb_sd_resp_rx.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared SD command-line constants, receiver state type and CRC7 step.
package sd_pkg;
   localparam logic [6:0] SD_CRC7_POLY = 7'h09;
   localparam int SD_RESP_LEN = 48;
   localparam int SD_CRC_SPAN = 40;
   typedef enum logic [1:0] {IDLE, WAIT_START, RECV} resp_rx_state_t;
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
      return {c[5:0], 1'b0} ^ ((d ^ c[6]) ? SD_CRC7_POLY : 7'h00);
   endfunction
endpackage

// File: rtl/sd_resp_rx_if.sv
// sd_resp_rx_if: command-FSM side (master) and response receiver side (slave).
interface sd_resp_rx_if;
   logic sample_en, cmd_in, arm, busy, resp_valid, crc_err, frame_err, timeout;
   logic [5:0] resp_index;
   logic [31:0] resp_arg;
   modport master (output sample_en, cmd_in, arm,
                   input busy, resp_valid, resp_index, resp_arg, crc_err, frame_err, timeout);
   modport slave (input sample_en, cmd_in, arm,
                  output busy, resp_valid, resp_index, resp_arg, crc_err, frame_err, timeout);
endinterface

// File: rtl/sd_crc7_serial.sv
// sd_crc7_serial: MSB-first serial CRC7 (x^7 + x^3 + 1), clear has priority over enable.
module sd_crc7_serial
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic       d,
   output logic [6:0] crc
);
   always_ff @(posedge clk)
      if (reset || clr) crc <= 7'h00;
      else if (en) crc <= crc7_step(crc, d);
endmodule

// File: rtl/sd_resp_rx.sv
// sd_resp_rx: hunts for a 48-bit SD response on CMD, checks CRC7 and framing,
// and reports the decoded index/argument or a start-bit timeout.
module sd_resp_rx
   import sd_pkg::*;
#(
   parameter int NCR_MAX   = 64,
   parameter bit CHECK_CRC = 1'b1
) (
   input logic        clk,
   input logic        reset,
   sd_resp_rx_if.slave bus
);
   localparam int WW = $clog2(NCR_MAX + 1);
   localparam int CRC_LO = SD_RESP_LEN - SD_CRC_SPAN;
   resp_rx_state_t state, state_d;
   logic [WW-1:0] wait_cnt;
   logic [5:0] bit_cnt;
   logic [38:0] sh;
   logic [6:0] rx_crc, crc;
   logic start, expire, rx_bit, done, crc_en;
   sd_crc7_serial u_crc (.clk(clk), .reset(reset), .clr(bus.arm), .en(crc_en), .d(bus.cmd_in), .crc(crc));
   always_comb begin
      start = state == WAIT_START && bus.sample_en && !bus.cmd_in;
      expire = state == WAIT_START && bus.sample_en && bus.cmd_in && wait_cnt == WW'(NCR_MAX - 1);
      rx_bit = state == RECV && bus.sample_en;
      done = rx_bit && bit_cnt == 6'd0;
      crc_en = start || (rx_bit && bit_cnt >= 6'(CRC_LO));
      state_d = bus.arm ? WAIT_START : start ? RECV : (expire || done) ? IDLE : state;
   end
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_d;
   // An arm coinciding with the completion pulse keeps busy asserted without a gap.
   assign bus.busy = state != IDLE || (bus.arm && bus.resp_valid);
   always_ff @(posedge clk)
      if (reset) begin
         wait_cnt <= '0;
         bit_cnt <= '0;
         sh <= '0;
         rx_crc <= '0;
         bus.resp_valid <= 1'b0;
         bus.timeout <= 1'b0;
         bus.resp_index <= '0;
         bus.resp_arg <= '0;
         bus.crc_err <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         bus.resp_valid <= done;
         bus.timeout <= expire && !bus.arm;
         wait_cnt <= bus.arm ? '0 : (state == WAIT_START && bus.sample_en && bus.cmd_in) ? wait_cnt + WW'(1) : wait_cnt;
         bit_cnt <= bus.arm ? '0 : start ? 6'(SD_RESP_LEN - 2) : rx_bit ? bit_cnt - 6'd1 : bit_cnt;
         if (rx_bit && bit_cnt >= 6'(CRC_LO)) sh <= {sh[37:0], bus.cmd_in};
         if (rx_bit && bit_cnt < 6'(CRC_LO) && bit_cnt != 6'd0) rx_crc <= {rx_crc[5:0], bus.cmd_in};
         if (done) begin
            bus.resp_index <= sh[37:32];
            bus.resp_arg <= sh[31:0];
            bus.crc_err <= CHECK_CRC && rx_crc != crc;
            bus.frame_err <= sh[38] || !bus.cmd_in;
         end else if (bus.arm) begin
            bus.crc_err <= 1'b0;
            bus.frame_err <= 1'b0;
         end
      end
endmodule

// File: tb/tb_sd_resp_rx.sv
// tb_sd_resp_rx: directed and randomized frames checked against a frame-level model every cycle.
module tb_sd_resp_rx;
   localparam int NCR = 64;
   logic clk = 1'b0, reset = 1'b1;
   int total = 0, bad = 0;
   int n_valid = 0, n_to = 0;
   sd_resp_rx_if bus();
   sd_resp_rx #(.NCR_MAX(NCR), .CHECK_CRC(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   int ph = 0, waits = 0;
   logic q[$];
   logic [47:0] mf;
   logic e_valid = 0, e_to = 0, e_crc = 0, e_frame = 0;
   logic [5:0] e_idx = 0;
   logic [31:0] e_arg = 0;

   function automatic logic [6:0] crc_ref(input logic [39:0] m);
      logic [46:0] r;
      r = {m, 7'b0};
      for (int i = 46; i >= 7; i--) if (r[i]) r = r ^ (47'h89 << (i - 7));
      return r[6:0];
   endfunction

   function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg,
                                              input logic tbit, input logic [6:0] flip, input logic endb);
      return {1'b0, tbit, idx, arg, crc_ref({1'b0, tbit, idx, arg}) ^ flip, endb};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("busy", 64'(bus.busy), 64'((ph != 0) || (bus.arm && e_valid)));
      check("resp_valid", 64'(bus.resp_valid), 64'(e_valid));
      check("timeout", 64'(bus.timeout), 64'(e_to));
      check("resp_index", 64'(bus.resp_index), 64'(e_idx));
      check("resp_arg", 64'(bus.resp_arg), 64'(e_arg));
      check("crc_err", 64'(bus.crc_err), 64'(e_crc));
      check("frame_err", 64'(bus.frame_err), 64'(e_frame));
      n_valid += int'(bus.resp_valid === 1'b1);
      n_to += int'(bus.timeout === 1'b1);
      if (reset) begin
         ph = 0; waits = 0; q.delete();
         e_valid = 0; e_to = 0; e_crc = 0; e_frame = 0; e_idx = 0; e_arg = 0;
      end else begin
         e_valid = 0; e_to = 0;
         if (bus.sample_en && ph == 2) begin
            q.push_back(bus.cmd_in);
            if (q.size() == 47) begin
               mf[47] = 1'b0;
               for (int i = 0; i < 47; i++) mf[46 - i] = q[i];
               e_valid = 1; e_idx = mf[45:40]; e_arg = mf[39:8];
               e_crc = mf[7:1] != crc_ref(mf[47:8]);
               e_frame = mf[46] || !mf[0];
               ph = 0;
            end
         end else if (bus.sample_en && ph == 1) begin
            if (!bus.cmd_in) begin
               ph = 2; q.delete();
            end else begin
               waits++;
               if (waits == NCR) begin e_to = 1; ph = 0; end
            end
         end
         if (bus.arm) begin
            ph = 1; waits = 0; q.delete(); e_to = 0;
            if (!e_valid) begin e_crc = 0; e_frame = 0; end
         end
      end
   end

   task automatic cyc(input logic a, input logic s, input logic c);
      bus.arm = a; bus.sample_en = s; bus.cmd_in = c;
      @(posedge clk); #1;
   endtask

   task automatic send_bit(input logic b, input int p);
      repeat (p - 1) cyc(1'b0, 1'b0, b);
      cyc(1'b0, 1'b1, b);
   endtask

   task automatic send_frame(input logic [47:0] f, input int p, input int pre, input int nbits);
      cyc(1'b1, 1'b0, 1'b1);
      repeat (pre) send_bit(1'b1, p);
      for (int i = 47; i > 47 - nbits; i--) send_bit(f[i], p);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] fa, fb, fc, fr;
      int nv, nt;
      bus.arm = 0; bus.sample_en = 0; bus.cmd_in = 1;
      repeat (3) cyc(1'b0, 1'b0, 1'b1);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_index", 64'(bus.resp_index), 64'd0);
      check("reset_arg", 64'(bus.resp_arg), 64'd0);
      reset = 0;
      cyc(1'b0, 1'b0, 1'b1);
      fa = make_frame(6'd17, 32'h0000_0900, 1'b0, 7'd0, 1'b1);
      check("model_crc_cmd17", 64'(fa), 64'h11_0000_0900_67);
      check("model_crc_51", 64'(crc_ref(40'h51_0000_0000)), 64'h2A);
      nv = n_valid;
      send_frame(fa, 1, 3, 48);
      cyc(1'b0, 1'b0, 1'b1);
      check("a_count", 64'(n_valid), 64'(nv + 1));
      check("a_index", 64'(bus.resp_index), 64'd17);
      check("a_arg", 64'(bus.resp_arg), 64'h900);
      check("a_crc_err", 64'(bus.crc_err), 64'd0);
      check("a_frame_err", 64'(bus.frame_err), 64'd0);
      fb = make_frame(6'd17, 32'h0000_0900, 1'b0, 7'd1, 1'b1);
      check("b_frame", 64'(fb[7:1]), 64'b0110010);
      send_frame(fb, 1, 0, 48);
      cyc(1'b0, 1'b0, 1'b1);
      check("b_crc_err", 64'(bus.crc_err), 64'd1);
      check("b_index", 64'(bus.resp_index), 64'd17);
      check("b_arg", 64'(bus.resp_arg), 64'h900);
      fc = make_frame(6'h11, 32'h0, 1'b1, 7'd0, 1'b1);
      check("c_first_byte", 64'(fc[47:40]), 64'h51);
      send_frame(fc, 1, 5, 48);
      cyc(1'b0, 1'b0, 1'b1);
      check("c_crc_err", 64'(bus.crc_err), 64'd0);
      check("c_frame_err", 64'(bus.frame_err), 64'd1);
      nv = n_valid; nt = n_to;
      cyc(1'b1, 1'b0, 1'b1);
      repeat (NCR - 1) send_bit(1'b1, 1);
      check("d_no_early_timeout", 64'(bus.timeout), 64'd0);
      check("d_busy_before", 64'(bus.busy), 64'd1);
      send_bit(1'b1, 1);
      check("d_timeout", 64'(bus.timeout), 64'd1);
      check("d_busy_after", 64'(bus.busy), 64'd0);
      cyc(1'b0, 1'b0, 1'b1);
      check("d_to_count", 64'(n_to), 64'(nt + 1));
      check("d_no_valid", 64'(n_valid), 64'(nv));
      nt = n_to;
      send_frame(fa, 1, NCR - 1, 48);
      cyc(1'b0, 1'b0, 1'b1);
      check("e_start_at_limit", 64'(n_valid), 64'(nv + 1));
      check("e_no_timeout", 64'(n_to), 64'(nt));
      send_frame(fa, 4, 2, 20);
      reset = 1;
      cyc(1'b0, 1'b0, 1'b1);
      reset = 0;
      check("f_busy_reset", 64'(bus.busy), 64'd0);
      check("f_index_reset", 64'(bus.resp_index), 64'd0);
      send_frame(fa, 4, 5, 48);
      cyc(1'b0, 1'b0, 1'b1);
      check("f_index", 64'(bus.resp_index), 64'd17);
      check("f_arg", 64'(bus.resp_arg), 64'h900);
      nv = n_valid;
      send_frame(make_frame(6'd3, 32'hDEAD_BEEF, 1'b0, 7'd0, 1'b1), 1, 2, 10);
      send_frame(fa, 1, 1, 48);
      cyc(1'b1, 1'b0, 1'b1);
      check("g_single_valid", 64'(n_valid), 64'(nv + 1));
      check("g_busy_rearmed", 64'(bus.busy), 64'd1);
      for (int k = 0; k < 40; k++) begin
         fr = make_frame(6'($urandom_range(0, 63)), 32'($urandom),
                         1'($urandom_range(0, 7) == 0),
                         ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'd0,
                         1'($urandom_range(0, 7) != 0));
         send_frame(fr, int'($urandom_range(1, 3)), int'($urandom_range(0, 70)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 47)) : 48);
         repeat ($urandom_range(0, 3)) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      repeat (3) cyc(1'b0, 1'b0, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
